mem_port_arbiter: RTL and testbench

//  Shares one synchronous single-port SRAM between the core's instruction-fetch

---
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and data memory.
// Optional define ARB_PERF_CNT_EN adds stall/grant performance counters.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            dm_req,
    input  logic [DW/8-1:0] dm_we,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic            dm_gnt,
    output logic            dm_rvalid,
    output logic [DW-1:0]   dm_rdata,
    output logic            sram_en,
    output logic [DW/8-1:0] sram_we,
    output logic [AW-1:0]   sram_addr,
    output logic [DW-1:0]   sram_wdata,
    input  logic [DW-1:0]   sram_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]     perf_if_stall,
    output logic [31:0]     perf_dm_stall,
    output logic [31:0]     perf_grants
`endif
);

    typedef enum logic [1:0] {RESP_NONE, RESP_IF, RESP_DM} resp_e;

    resp_e      resp_sel_q;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       force_if;

    // A starved fetch overrides data priority for exactly one cycle.
    assign force_if = if_req && (starve_cnt_q == 4'(STARVE_MAX));

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (force_if)    if_gnt = 1'b1;
        else if (dm_req) dm_gnt = 1'b1;
        else if (if_req) if_gnt = 1'b1;
    end

    always_comb begin
        sram_en    = if_gnt | dm_gnt;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (dm_gnt) begin
            sram_we    = dm_we;
            sram_addr  = dm_addr;
            sram_wdata = dm_wdata;
        end else if (if_gnt) begin
            sram_addr  = if_addr;
        end
    end

    always_comb begin
        if (!if_req || if_gnt)                      starve_cnt_d = 4'd0;
        else if (starve_cnt_q == 4'(STARVE_MAX))    starve_cnt_d = starve_cnt_q;
        else                                        starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // Tracks which requester owns the read data returning next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_sel_q   <= RESP_NONE;
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            if (if_gnt)                      resp_sel_q <= RESP_IF;
            else if (dm_gnt && dm_we == '0)  resp_sel_q <= RESP_DM;
            else                             resp_sel_q <= RESP_NONE;
        end
    end

    assign if_rvalid = (resp_sel_q == RESP_IF);
    assign dm_rvalid = (resp_sel_q == RESP_DM);
    assign if_rdata  = sram_rdata;
    assign dm_rdata  = sram_rdata;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall_q, perf_dm_stall_q, perf_grants_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_if_stall_q <= '0;
            perf_dm_stall_q <= '0;
            perf_grants_q   <= '0;
        end else begin
            if (if_req && !if_gnt) perf_if_stall_q <= perf_if_stall_q + 32'd1;
            if (dm_req && !dm_gnt) perf_dm_stall_q <= perf_dm_stall_q + 32'd1;
            if (sram_en)           perf_grants_q   <= perf_grants_q + 32'd1;
        end
    end

    assign perf_if_stall = perf_if_stall_q;
    assign perf_dm_stall = perf_dm_stall_q;
    assign perf_grants   = perf_grants_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter with a transaction-level model
// and a behavioural SRAM; perf counters are checked when ARB_PERF_CNT_EN is set.
module tb_mem_port_arbiter;
    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req, dm_req;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [3:0]  dm_we;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, sram_en;
    logic [31:0] if_rdata, dm_rdata, sram_addr, sram_wdata;
    logic [31:0] sram_rdata = '0;
    logic [3:0]  sram_we;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall, perf_dm_stall, perf_grants;
    int unsigned m_pif, m_pdm, m_pgr;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_MAX(SM), .AW(32), .DW(32)) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
`ifdef ARB_PERF_CNT_EN
        , .perf_if_stall(perf_if_stall), .perf_dm_stall(perf_dm_stall), .perf_grants(perf_grants)
`endif
    );

    // Behavioural SRAM driven by the DUT, and a separate shadow memory for the model.
    logic [31:0] bm  [int unsigned];
    logic [31:0] shm [int unsigned];

    function automatic logic [31:0] init_word(int unsigned k);
        return (k * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == 4'h0) begin
                sram_rdata <= bm.exists(sram_addr >> 2) ? bm[sram_addr >> 2] : init_word(sram_addr >> 2);
            end else begin
                logic [31:0] w;
                w = bm.exists(sram_addr >> 2) ? bm[sram_addr >> 2] : init_word(sram_addr >> 2);
                for (int b = 0; b < 4; b++) if (sram_we[b]) w[b*8 +: 8] = sram_wdata[b*8 +: 8];
                bm[sram_addr >> 2] = w;
            end
        end
    end

    function automatic logic [31:0] shm_rd(logic [31:0] a);
        return shm.exists(a >> 2) ? shm[a >> 2] : init_word(a >> 2);
    endfunction

    int n_chk = 0, n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: consecutive fetch denials, pending response owner (0/1=IF/2=DM), its data.
    int          m_den = 0;
    int          m_resp = 0;
    logic [31:0] m_data = '0;
    logic        p_if_gnt, p_dm_gnt;
    logic        l_if_gnt, l_dm_gnt, l_en, l_if_rv, l_dm_rv;
    logic [3:0]  l_we;
    logic [31:0] l_if_rd, l_dm_rd;

    // Called at posedge+1 with inputs set; compares at negedge, advances model, returns at next posedge+1.
    task automatic cyc();
        logic e_if, e_dm;
        @(negedge clk);
        if (!resetn) begin
            m_den = 0; m_resp = 0;
`ifdef ARB_PERF_CNT_EN
            m_pif = 0; m_pdm = 0; m_pgr = 0;
`endif
        end
        e_if = if_req && (m_den >= SM || !dm_req);
        e_dm = dm_req && !e_if;
        chk("if_gnt", {31'b0, if_gnt}, {31'b0, e_if});
        chk("dm_gnt", {31'b0, dm_gnt}, {31'b0, e_dm});
        chk("sram_en", {31'b0, sram_en}, {31'b0, e_if | e_dm});
        chk("sram_we", {28'b0, sram_we}, e_dm ? {28'b0, dm_we} : 32'h0);
        chk("sram_addr", sram_addr, e_dm ? dm_addr : (e_if ? if_addr : 32'h0));
        if (!e_if) chk("sram_wdata", sram_wdata, e_dm ? dm_wdata : 32'h0);
        chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, m_resp == 1});
        chk("dm_rvalid", {31'b0, dm_rvalid}, {31'b0, m_resp == 2});
        if (m_resp == 1) chk("if_rdata", if_rdata, m_data);
        if (m_resp == 2) chk("dm_rdata", dm_rdata, m_data);
`ifdef ARB_PERF_CNT_EN
        chk("perf_if_stall", perf_if_stall, m_pif);
        chk("perf_dm_stall", perf_dm_stall, m_pdm);
        chk("perf_grants", perf_grants, m_pgr);
`endif
        l_if_gnt = if_gnt; l_dm_gnt = dm_gnt; l_en = sram_en; l_we = sram_we;
        l_if_rv = if_rvalid; l_dm_rv = dm_rvalid; l_if_rd = if_rdata; l_dm_rd = dm_rdata;
        p_if_gnt = e_if; p_dm_gnt = e_dm;
        if (resetn) begin
            m_resp = 0;
            if (e_if) begin
                m_resp = 1; m_data = shm_rd(if_addr);
            end else if (e_dm && dm_we == 4'h0) begin
                m_resp = 2; m_data = shm_rd(dm_addr);
            end else if (e_dm) begin
                logic [31:0] w;
                w = shm_rd(dm_addr);
                for (int b = 0; b < 4; b++) if (dm_we[b]) w[b*8 +: 8] = dm_wdata[b*8 +: 8];
                shm[dm_addr >> 2] = w;
            end
            m_den = (if_req && !e_if) ? ((m_den + 1 > SM) ? SM : m_den + 1) : 0;
`ifdef ARB_PERF_CNT_EN
            if (if_req && !e_if) m_pif++;
            if (dm_req && !e_dm) m_pdm++;
            if (e_if || e_dm)    m_pgr++;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        cyc();
        resetn = 1'b1;
    endtask

    logic [9:0] gpat;

    initial begin
        resetn = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        if_addr = '0; dm_addr = '0; dm_we = '0; dm_wdata = '0;
        bm[32'h1C000000 >> 2]  = 32'hCAFEF00D;
        shm[32'h1C000000 >> 2] = 32'hCAFEF00D;
        @(posedge clk); #1;
        cyc();
        chk("reset_if_rvalid", {31'b0, l_if_rv}, 32'h0);
        chk("reset_sram_en", {31'b0, l_en}, 32'h0);
        resetn = 1'b1;

        // Fetch only
        if_req = 1'b1; if_addr = 32'h1C000000;
        cyc();
        chk("s1_if_gnt", {31'b0, l_if_gnt}, 32'h1);
        chk("s1_sram_we", {28'b0, l_we}, 32'h0);
        if_req = 1'b0;
        cyc();
        chk("s1_if_rvalid", {31'b0, l_if_rv}, 32'h1);
        chk("s1_if_rdata", l_if_rd, 32'hCAFEF00D);

        // Store then load to 0x100
        dm_req = 1'b1; dm_we = 4'hF; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
        cyc();
        chk("s2_st_gnt", {31'b0, l_dm_gnt}, 32'h1);
        dm_we = 4'h0; dm_wdata = 32'h0;
        cyc();
        chk("s2_st_no_rvalid", {31'b0, l_dm_rv}, 32'h0);
        dm_req = 1'b0;
        cyc();
        chk("s2_ld_rvalid", {31'b0, l_dm_rv}, 32'h1);
        chk("s2_ld_rdata", l_dm_rd, 32'hDEADBEEF);

        // Contention: data x4 then fetch, repeating with no idle cycle
        do_reset();
        cyc();
        if_req = 1'b1; dm_req = 1'b1; dm_we = 4'h0; dm_addr = 32'h40; if_addr = 32'h80;
        gpat = '0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            gpat[i] = l_if_gnt;
            chk("s3_no_idle", {31'b0, l_en}, 32'h1);
        end
        chk("s3_pattern", {22'b0, gpat}, 32'h210);
`ifdef ARB_PERF_CNT_EN
        chk("s6_perf_if", perf_if_stall, 32'd8);
        chk("s6_perf_dm", perf_dm_stall, 32'd2);
        chk("s6_perf_gr", perf_grants, 32'd10);
`endif

        // Alternating IF, DM, IF
        if_req = 1'b0; dm_req = 1'b0;
        cyc();
        if_req = 1'b1; if_addr = 32'h1C000000;
        cyc();
        if_req = 1'b0; dm_req = 1'b1; dm_addr = 32'h100; dm_we = 4'h0;
        cyc();
        chk("s4_if_rv", {31'b0, l_if_rv}, 32'h1);
        chk("s4_if_rd", l_if_rd, 32'hCAFEF00D);
        dm_req = 1'b0; if_req = 1'b1;
        cyc();
        chk("s4_dm_rv", {31'b0, l_dm_rv}, 32'h1);
        chk("s4_dm_rd", l_dm_rd, 32'hDEADBEEF);
        if_req = 1'b0;
        cyc();
        chk("s4_if_rv2", {31'b0, l_if_rv}, 32'h1);
        chk("s4_if_rd2", l_if_rd, 32'hCAFEF00D);

        // Reset the cycle after a fetch grant
        if_req = 1'b1;
        cyc();
        resetn = 1'b0; if_req = 1'b0;
        cyc();
        chk("s5_if_rv", {31'b0, l_if_rv}, 32'h0);
        chk("s5_sram_en", {31'b0, l_en}, 32'h0);
        cyc();
        chk("s5_if_rv_hold", {31'b0, l_if_rv}, 32'h0);
        resetn = 1'b1;

        // Randomized traffic, requests held until granted
        p_if_gnt = 1'b1; p_dm_gnt = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!if_req || p_if_gnt) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if (!dm_req || p_dm_gnt) begin
                dm_req   = ($urandom_range(0, 2) != 0);
                dm_addr  = 32'($urandom_range(0, 63)) << 2;
                dm_wdata = $urandom;
                case ($urandom_range(0, 3))
                    0, 1:    dm_we = 4'h0;
                    2:       dm_we = 4'hF;
                    default: dm_we = 4'($urandom_range(1, 15));
                endcase
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
